// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared widths, tag type and product sign-extension for the dot-product sequencer
package dsp_pkg;
    localparam int A_W = 25;
    localparam int B_W = 18;
    localparam int P_W = 48;
    localparam int M_W = 43;

    typedef struct packed {
        logic first;
        logic last;
    } dsp_tag_t;

    function automatic logic [P_W-1:0] sext_prod(input logic [M_W-1:0] m);
        return {{(P_W-M_W){m[M_W-1]}}, m};
    endfunction
endpackage

// File: rtl/dsp_25x18.sv
// rtl/dsp_25x18.sv - free-running 25x18 signed MAC slice: A/B registers, product register, P = M + pci
module dsp_25x18
    import dsp_pkg::*;
#(
    parameter int A_REG = 2,
    parameter int B_REG = 2
) (
    input  logic                  clk,
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    input  logic        [P_W-1:0] pci_i,
    output logic        [P_W-1:0] p_o
);
    logic signed [A_W-1:0] a_q [A_REG];
    logic signed [B_W-1:0] b_q [B_REG];
    logic signed [M_W-1:0] a_x, b_x, m_q;
    logic        [P_W-1:0] p_q;

    // No reset and no enable: the slice clocks every cycle
    always_ff @(posedge clk) begin
        a_q[0] <= a_i;
        for (int i = 1; i < A_REG; i++) a_q[i] <= a_q[i-1];
        b_q[0] <= b_i;
        for (int i = 1; i < B_REG; i++) b_q[i] <= b_q[i-1];
    end

    assign a_x = M_W'(a_q[A_REG-1]);
    assign b_x = M_W'(b_q[B_REG-1]);

    always_ff @(posedge clk) begin
        m_q <= a_x * b_x;
        p_q <= sext_prod(m_q) + pci_i;
    end

    assign p_o = p_q;
endmodule

// File: rtl/dsp_res_fifo.sv
// rtl/dsp_res_fifo.sv - synchronous result FIFO, head presented combinationally, zero when empty
module dsp_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, do_wr, do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_wr   = wr_en_i && !full;
    assign do_rd   = rd_en_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_wr && !do_rd)      count_q <= count_q + CW'(1);
            else if (do_rd && !do_wr) count_q <= count_q - CW'(1);
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/dsp_dot_ctrl.sv
// rtl/dsp_dot_ctrl.sv - sequences operand beats through one MAC slice and queues one sum per vector
module dsp_dot_ctrl
    import dsp_pkg::*;
#(
    parameter int A_REG     = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [A_W-1:0] s_a,
    input  logic signed [B_W-1:0] s_b,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [P_W-1:0] m_data
);
    localparam int CRW = $clog2(OUT_DEPTH + 1);

    logic                  accept, pop, fifo_empty;
    logic signed [A_W-1:0] dsp_a;
    logic signed [B_W-1:0] dsp_b;
    logic        [P_W-1:0] p, pci, fifo_head;
    dsp_tag_t              tag_in;
    logic [A_REG:0]        first_sr_q, first_sr_d;
    logic [A_REG+1:0]      last_sr_q, last_sr_d;
    logic                  first_pend_q, first_pend_d;
    logic [CRW-1:0]        credits_q, credits_d;
    logic                  first_aligned, last_aligned;

    assign accept = s_valid && s_ready;
    assign pop    = m_valid && m_ready;

    // Bubbles feed zero operands so the running sum just holds
    assign dsp_a = accept ? s_a : '0;
    assign dsp_b = accept ? s_b : '0;

    assign tag_in.first = accept && first_pend_q;
    assign tag_in.last  = accept && s_last;

    assign first_aligned = first_sr_q[A_REG];
    assign last_aligned  = last_sr_q[A_REG+1];
    assign pci           = first_aligned ? '0 : p;

    always_comb begin
        first_sr_d   = {first_sr_q[A_REG-1:0], tag_in.first};
        last_sr_d    = {last_sr_q[A_REG:0], tag_in.last};
        first_pend_d = accept ? s_last : first_pend_q;
        credits_d    = credits_q;
        if (tag_in.last && !pop)      credits_d = credits_q - CRW'(1);
        else if (pop && !tag_in.last) credits_d = credits_q + CRW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_sr_q   <= '0;
            last_sr_q    <= '0;
            first_pend_q <= 1'b1;
            credits_q    <= CRW'(OUT_DEPTH);
        end else begin
            first_sr_q   <= first_sr_d;
            last_sr_q    <= last_sr_d;
            first_pend_q <= first_pend_d;
            credits_q    <= credits_d;
        end
    end

    assign s_ready = (credits_q != '0);

    dsp_25x18 #(
        .A_REG (A_REG),
        .B_REG (A_REG)
    ) u_slice (
        .clk   (clk),
        .a_i   (dsp_a),
        .b_i   (dsp_b),
        .pci_i (pci),
        .p_o   (p)
    );

    // Credits guarantee a free slot for every result already in the slice pipeline
    dsp_res_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (P_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (last_aligned),
        .wr_data_i (p),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_head;
endmodule
